// File: rtl/battlefront_calc.sv
// battlefront_calc
//
// Purpose: runs one battle round for each rising edge of the game tick.
// A round scans four player-unit slots and four enemy slots to find each
// side's front position and target slot, then strobes moveSCEN. After
// one settle cycle it sums the damage of every alive unit and every alive
// enemy. Each sum goes to the opposing front slot, and damageSCEN is
// strobed.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   gameClk        game tick level; each sampled 0->1 edge in IDLE starts a round
//   unitPos/Dmg/Type    4 player-unit slots (9-bit pos, 8-bit dmg, 2-bit type)
//   enemyPos/Dmg/Type   4 enemy slots, same packing
//   moveSCEN       one-cycle move strobe
//   damageSCEN     one-cycle damage-apply strobe
//   enemyFront     max position of alive enemies (0 if none)
//   unitFront      min position of alive units (511 if none)
//   unitDamageBus  per-slot damageIn for units, only the unitTarget slot non-zero
//   enemyDamageBus per-slot damageIn for enemies, only the enemyTarget slot non-zero
//   unitTarget     slot index of the front alive unit
//   enemyTarget    slot index of the front alive enemy
//   busy           high whenever a round is in progress
//
// Configuration macro: BATTLEFRONT_SATURATE_EN
//   defined   -> damage sums saturate at 255
//   undefined -> damage sums wrap modulo 256

module battlefront_calc (
  input  logic        clk,
  input  logic        reset,
  input  logic        gameClk,
  input  logic [35:0] unitPos,
  input  logic [31:0] unitDmg,
  input  logic [7:0]  unitType,
  input  logic [35:0] enemyPos,
  input  logic [31:0] enemyDmg,
  input  logic [7:0]  enemyType,
  output logic        moveSCEN,
  output logic        damageSCEN,
  output logic [8:0]  enemyFront,
  output logic [8:0]  unitFront,
  output logic [31:0] unitDamageBus,
  output logic [31:0] enemyDamageBus,
  output logic [1:0]  unitTarget,
  output logic [1:0]  enemyTarget,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    MOVE,
    SETTLE,
    SUM,
    DAMAGE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        gclk_q;

  // scan accumulators
  logic        u_found_q, u_found_d;
  logic [8:0]  u_min_q, u_min_d;
  logic [1:0]  u_tgt_q, u_tgt_d;
  logic        e_found_q, e_found_d;
  logic [8:0]  e_max_q, e_max_d;
  logic [1:0]  e_tgt_q, e_tgt_d;

  // damage sums
  logic [7:0]  u_sum_q, u_sum_d;
  logic [7:0]  e_sum_q, e_sum_d;

  // registered outputs
  logic        move_scen_q, move_scen_d;
  logic        damage_scen_q, damage_scen_d;
  logic        busy_q, busy_d;
  logic [8:0]  unit_front_q, unit_front_d;
  logic [8:0]  enemy_front_q, enemy_front_d;
  logic [1:0]  unit_target_q, unit_target_d;
  logic [1:0]  enemy_target_q, enemy_target_d;
  logic        unit_any_q, unit_any_d;
  logic        enemy_any_q, enemy_any_d;
  logic [31:0] unit_bus_q, unit_bus_d;
  logic [31:0] enemy_bus_q, enemy_bus_d;

  // current slot, shared by SCAN and SUM
  logic [8:0]  u_pos_s, e_pos_s;
  logic [7:0]  u_dmg_s, e_dmg_s;
  logic        u_alive_s, e_alive_s;
  logic        tick;

  assign u_pos_s   = unitPos[9*idx_q +: 9];
  assign e_pos_s   = enemyPos[9*idx_q +: 9];
  assign u_dmg_s   = unitDmg[8*idx_q +: 8];
  assign e_dmg_s   = enemyDmg[8*idx_q +: 8];
  assign u_alive_s = |unitType[2*idx_q +: 2];
  assign e_alive_s = |enemyType[2*idx_q +: 2];

  // Ticks only count in IDLE; a rise during a round is simply lost.
  assign tick = (state_q == IDLE) && !gclk_q && gameClk;

  function automatic logic [7:0] add_dmg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef BATTLEFRONT_SATURATE_EN
    return s[8] ? 8'hFF : s[7:0];
`else
    return s[7:0];
`endif
  endfunction

  // Next-state and datapath. Fronts/targets are captured on the SCAN->MOVE
  // edge using the _d values so slot 3 is included. Strict compares keep the
  // lowest slot on ties because slots are visited in ascending order.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    u_found_d      = u_found_q;
    u_min_d        = u_min_q;
    u_tgt_d        = u_tgt_q;
    e_found_d      = e_found_q;
    e_max_d        = e_max_q;
    e_tgt_d        = e_tgt_q;
    u_sum_d        = u_sum_q;
    e_sum_d        = e_sum_q;
    move_scen_d    = 1'b0;
    damage_scen_d  = 1'b0;
    unit_front_d   = unit_front_q;
    enemy_front_d  = enemy_front_q;
    unit_target_d  = unit_target_q;
    enemy_target_d = enemy_target_q;
    unit_any_d     = unit_any_q;
    enemy_any_d    = enemy_any_q;
    unit_bus_d     = unit_bus_q;
    enemy_bus_d    = enemy_bus_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = SCAN;
          idx_d     = 2'd0;
          u_found_d = 1'b0;
          u_min_d   = 9'd511;
          u_tgt_d   = 2'd0;
          e_found_d = 1'b0;
          e_max_d   = 9'd0;
          e_tgt_d   = 2'd0;
        end
      end
      SCAN: begin
        if (u_alive_s && (!u_found_q || (u_pos_s < u_min_q))) begin
          u_found_d = 1'b1;
          u_min_d   = u_pos_s;
          u_tgt_d   = idx_q;
        end
        if (e_alive_s && (!e_found_q || (e_pos_s > e_max_q))) begin
          e_found_d = 1'b1;
          e_max_d   = e_pos_s;
          e_tgt_d   = idx_q;
        end
        idx_d = 2'(idx_q + 2'd1);
        if (idx_q == 2'd3) begin
          state_d        = MOVE;
          move_scen_d    = 1'b1;
          unit_front_d   = u_min_d;
          enemy_front_d  = e_max_d;
          unit_target_d  = u_tgt_d;
          enemy_target_d = e_tgt_d;
          unit_any_d     = u_found_d;
          enemy_any_d    = e_found_d;
        end
      end
      MOVE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        // Units latch their post-move damageOut here; the previous
        // round's buses are dropped as summing starts.
        state_d     = SUM;
        idx_d       = 2'd0;
        u_sum_d     = 8'd0;
        e_sum_d     = 8'd0;
        unit_bus_d  = 32'd0;
        enemy_bus_d = 32'd0;
      end
      SUM: begin
        if (u_alive_s) u_sum_d = add_dmg(u_sum_q, u_dmg_s);
        if (e_alive_s) e_sum_d = add_dmg(e_sum_q, e_dmg_s);
        idx_d = 2'(idx_q + 2'd1);
        if (idx_q == 2'd3) begin
          state_d       = DAMAGE;
          damage_scen_d = 1'b1;
          unit_bus_d    = 32'd0;
          enemy_bus_d   = 32'd0;
          if (unit_any_q)  unit_bus_d[8*unit_target_q +: 8]   = e_sum_d;
          if (enemy_any_q) enemy_bus_d[8*enemy_target_q +: 8] = u_sum_d;
        end
      end
      DAMAGE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register. gclk_q keeps tracking gameClk through reset so a level
  // already high at release is not mistaken for a new tick.
  always_ff @(posedge clk) begin
    gclk_q <= gameClk;
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      u_found_q      <= 1'b0;
      u_min_q        <= 9'd511;
      u_tgt_q        <= 2'd0;
      e_found_q      <= 1'b0;
      e_max_q        <= 9'd0;
      e_tgt_q        <= 2'd0;
      u_sum_q        <= 8'd0;
      e_sum_q        <= 8'd0;
      move_scen_q    <= 1'b0;
      damage_scen_q  <= 1'b0;
      busy_q         <= 1'b0;
      unit_front_q   <= 9'd511;
      enemy_front_q  <= 9'd0;
      unit_target_q  <= 2'd0;
      enemy_target_q <= 2'd0;
      unit_any_q     <= 1'b0;
      enemy_any_q    <= 1'b0;
      unit_bus_q     <= 32'd0;
      enemy_bus_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      u_found_q      <= u_found_d;
      u_min_q        <= u_min_d;
      u_tgt_q        <= u_tgt_d;
      e_found_q      <= e_found_d;
      e_max_q        <= e_max_d;
      e_tgt_q        <= e_tgt_d;
      u_sum_q        <= u_sum_d;
      e_sum_q        <= e_sum_d;
      move_scen_q    <= move_scen_d;
      damage_scen_q  <= damage_scen_d;
      busy_q         <= busy_d;
      unit_front_q   <= unit_front_d;
      enemy_front_q  <= enemy_front_d;
      unit_target_q  <= unit_target_d;
      enemy_target_q <= enemy_target_d;
      unit_any_q     <= unit_any_d;
      enemy_any_q    <= enemy_any_d;
      unit_bus_q     <= unit_bus_d;
      enemy_bus_q    <= enemy_bus_d;
    end
  end

  assign moveSCEN       = move_scen_q;
  assign damageSCEN     = damage_scen_q;
  assign busy           = busy_q;
  assign unitFront      = unit_front_q;
  assign enemyFront     = enemy_front_q;
  assign unitTarget     = unit_target_q;
  assign enemyTarget    = enemy_target_q;
  assign unitDamageBus  = unit_bus_q;
  assign enemyDamageBus = enemy_bus_q;

endmodule

// File: tb/tb_battlefront_calc.sv
// tb_battlefront_calc
//
// Purpose: self-checking bench for battlefront_calc. Directed rounds cover
// the worked examples, and randomized rounds follow them. Expected results
// come from a slot-array model that finds the extreme alive positions and
// sums the damage. The model honours BATTLEFRONT_SATURATE_EN in the same
// way as the design.

module tb_battlefront_calc;

  logic        clk;
  logic        reset;
  logic        gameClk;
  logic [35:0] unitPos, enemyPos;
  logic [31:0] unitDmg, enemyDmg;
  logic [7:0]  unitType, enemyType;
  logic        moveSCEN, damageSCEN, busy;
  logic [8:0]  enemyFront, unitFront;
  logic [31:0] unitDamageBus, enemyDamageBus;
  logic [1:0]  unitTarget, enemyTarget;

  battlefront_calc dut (
    .clk            (clk),
    .reset          (reset),
    .gameClk        (gameClk),
    .unitPos        (unitPos),
    .unitDmg        (unitDmg),
    .unitType       (unitType),
    .enemyPos       (enemyPos),
    .enemyDmg       (enemyDmg),
    .enemyType      (enemyType),
    .moveSCEN       (moveSCEN),
    .damageSCEN     (damageSCEN),
    .enemyFront     (enemyFront),
    .unitFront      (unitFront),
    .unitDamageBus  (unitDamageBus),
    .enemyDamageBus (enemyDamageBus),
    .unitTarget     (unitTarget),
    .enemyTarget    (enemyTarget),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slot contents; dmgPre is driven before the move, dmgPost after it
  int uPos[4], uType[4], uDmgPre[4], uDmgPost[4];
  int ePos[4], eType[4], eDmgPre[4], eDmgPost[4];

  int expUFront, expUTgt, expEFront, expETgt;
  logic [31:0] expUBus, expEBus;

  int checkCount = 0;
  int passCount  = 0;
  int moveCount  = 0;
  int damageCount = 0;
  int bothCount  = 0;

  // Strobe counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (moveSCEN)              moveCount   <= moveCount + 1;
    if (damageSCEN)            damageCount <= damageCount + 1;
    if (moveSCEN && damageSCEN) bothCount  <= bothCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drive the slot arrays onto the packed ports.
  task automatic applyStimulus(input bit postMove);
    for (int i = 0; i < 4; i++) begin
      unitPos[9*i +: 9]   = 9'(uPos[i]);
      enemyPos[9*i +: 9]  = 9'(ePos[i]);
      unitType[2*i +: 2]  = 2'(uType[i]);
      enemyType[2*i +: 2] = 2'(eType[i]);
      unitDmg[8*i +: 8]   = 8'(postMove ? uDmgPost[i] : uDmgPre[i]);
      enemyDmg[8*i +: 8]  = 8'(postMove ? eDmgPost[i] : eDmgPre[i]);
    end
  endtask

  function automatic int limitSum(input int s);
`ifdef BATTLEFRONT_SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  // Reference: extreme alive position first, then the first slot holding it.
  task automatic computeModel();
    int uSum, eSum;
    bit uAny, eAny;
    uAny = 0; eAny = 0;
    expUFront = 511; expEFront = 0; expUTgt = 0; expETgt = 0;
    uSum = 0; eSum = 0;
    for (int i = 0; i < 4; i++) begin
      if (uType[i] != 0) begin
        uAny = 1;
        if (uPos[i] < expUFront) expUFront = uPos[i];
        uSum += uDmgPost[i];
      end
      if (eType[i] != 0) begin
        eAny = 1;
        if (ePos[i] > expEFront) expEFront = ePos[i];
        eSum += eDmgPost[i];
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (uType[i] != 0 && uPos[i] == expUFront) expUTgt = i;
      if (eType[i] != 0 && ePos[i] == expEFront) expETgt = i;
    end
    expUBus = uAny ? (32'(limitSum(eSum)) << (8*expUTgt)) : 32'd0;
    expEBus = eAny ? (32'(limitSum(uSum)) << (8*expETgt)) : 32'd0;
  endtask

  task automatic runRound(input string name, input bit extraTick);
    int k, mv0, dm0, both0;
    mv0 = moveCount; dm0 = damageCount; both0 = bothCount;
    applyStimulus(0);
    computeModel();
    @(negedge clk);
    gameClk = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) gameClk = 1'b0;
      if (moveSCEN) break;
    end
    gameClk = 1'b0;
    checkOutput({name, ":moveLatency"}, 32'(k), 32'd5);
    checkOutput({name, ":unitFront"}, 32'(unitFront), 32'(expUFront));
    checkOutput({name, ":unitTarget"}, 32'(unitTarget), 32'(expUTgt));
    checkOutput({name, ":enemyFront"}, 32'(enemyFront), 32'(expEFront));
    checkOutput({name, ":enemyTarget"}, 32'(enemyTarget), 32'(expETgt));
    checkOutput({name, ":busyInRound"}, 32'(busy), 32'd1);
    applyStimulus(1);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (extraTick && k == 2) gameClk = 1'b1;
      if (extraTick && k == 4) gameClk = 1'b0;
      if (damageSCEN) break;
    end
    gameClk = 1'b0;
    checkOutput({name, ":damageLatency"}, 32'(k), 32'd6);
    checkOutput({name, ":unitDamageBus"}, unitDamageBus, expUBus);
    checkOutput({name, ":enemyDamageBus"}, enemyDamageBus, expEBus);
    repeat (8) @(negedge clk);
    checkOutput({name, ":busyAfter"}, 32'(busy), 32'd0);
    checkOutput({name, ":moveStrobes"}, 32'(moveCount - mv0), 32'd1);
    checkOutput({name, ":damageStrobes"}, 32'(damageCount - dm0), 32'd1);
    checkOutput({name, ":bothStrobes"}, 32'(bothCount - both0), 32'd0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ":moveSCEN"}, 32'(moveSCEN), 32'd0);
    checkOutput({name, ":damageSCEN"}, 32'(damageSCEN), 32'd0);
    checkOutput({name, ":busy"}, 32'(busy), 32'd0);
    checkOutput({name, ":unitFront"}, 32'(unitFront), 32'd511);
    checkOutput({name, ":enemyFront"}, 32'(enemyFront), 32'd0);
    checkOutput({name, ":targets"}, {28'd0, unitTarget, enemyTarget}, 32'd0);
    checkOutput({name, ":unitDamageBus"}, unitDamageBus, 32'd0);
    checkOutput({name, ":enemyDamageBus"}, enemyDamageBus, 32'd0);
  endtask

  task automatic setSlots(input int up0, up1, up2, up3, ut0, ut1, ut2, ut3,
                          input int ep0, ep1, ep2, ep3, et0, et1, et2, et3);
    uPos = '{up0, up1, up2, up3};  uType = '{ut0, ut1, ut2, ut3};
    ePos = '{ep0, ep1, ep2, ep3};  eType = '{et0, et1, et2, et3};
  endtask

  initial begin
    int dm0;
    reset = 1'b0;
    gameClk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      uPos[i] = 0; uType[i] = 0; uDmgPre[i] = 0; uDmgPost[i] = 0;
      ePos[i] = 0; eType[i] = 0; eDmgPre[i] = 0; eDmgPost[i] = 0;
    end
    applyStimulus(0);
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // worked example: fronts, targets and summed damage
    setSlots(300, 400, 50, 60, 1, 2, 0, 0, 100, 150, 500, 510, 3, 1, 0, 0);
    uDmgPre  = '{7, 9, 11, 13};  eDmgPre  = '{40, 50, 99, 99};
    uDmgPost = '{32, 0, 77, 88}; eDmgPost = '{40, 50, 66, 44};
    runRound("basic", 0);

    // no alive enemies
    setSlots(200, 100, 100, 300, 1, 0, 2, 3, 10, 20, 30, 40, 0, 0, 0, 0);
    uDmgPost = '{5, 6, 7, 8}; eDmgPost = '{9, 9, 9, 9};
    runRound("noEnemy", 0);

    // no alive units, plus a tie on the enemy side
    setSlots(10, 20, 30, 40, 0, 0, 0, 0, 250, 300, 300, 12, 1, 1, 2, 0);
    uDmgPost = '{1, 2, 3, 4}; eDmgPost = '{10, 20, 30, 40};
    runRound("noUnit", 0);

    // sum overflow: saturate or wrap depending on the build
    setSlots(80, 90, 0, 0, 1, 1, 0, 0, 50, 60, 0, 0, 2, 2, 0, 0);
    uDmgPost = '{200, 100, 0, 0}; eDmgPost = '{128, 128, 0, 0};
    runRound("overflow", 0);

    // second tick during SUM is dropped
    setSlots(300, 400, 0, 0, 1, 2, 0, 0, 100, 150, 0, 0, 3, 1, 0, 0);
    uDmgPost = '{32, 0, 0, 0}; eDmgPost = '{40, 50, 0, 0};
    runRound("extraTick", 1);

    // reset during SETTLE aborts the round
    @(negedge clk);
    gameClk = 1'b1;
    repeat (2) @(negedge clk);
    gameClk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    gameClk = 1'b1;
    dm0 = damageCount;
    repeat (2) @(negedge clk);
    checkResetValues("midReset");
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("midReset:noDamage", 32'(damageCount - dm0), 32'd0);
    checkOutput("midReset:highLevelNoRound", 32'(busy), 32'd0);
    gameClk = 1'b0;
    repeat (2) @(negedge clk);
    runRound("afterReset", 0);

    // randomized rounds
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) begin
        uPos[i] = ($urandom_range(0, 2) == 0) ? 100 * $urandom_range(0, 3) : $urandom_range(0, 511);
        ePos[i] = ($urandom_range(0, 2) == 0) ? 100 * $urandom_range(0, 3) : $urandom_range(0, 511);
        uType[i] = $urandom_range(0, 3);
        eType[i] = $urandom_range(0, 3);
        uDmgPre[i] = $urandom_range(0, 255);
        eDmgPre[i] = $urandom_range(0, 255);
        uDmgPost[i] = $urandom_range(0, 255);
        eDmgPost[i] = $urandom_range(0, 255);
      end
      runRound($sformatf("rand%0d", r), r[0]);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/battlefront_calc.md
BATTLEFRONT_CALC -- requirements
Module: battlefront_calc

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-003 gameClk  input  1  game tick, level signal; each 0->1 transition sampled on clk starts one battle round.
REQ-004 unitPos  input  36  4 x 9-bit player-unit positions; slot i occupies bits [9i+8:9i].
REQ-005 unitDmg  input  32  4 x 8-bit player-unit damageOut; slot i occupies bits [8i+7:8i].
REQ-006 unitType  input  8  4 x 2-bit player-unit type; 00 means dead or empty.
REQ-007 enemyPos, enemyDmg, enemyType  input  36/32/8  enemy slots, same packing as REQ-004 to REQ-006.
REQ-008 moveSCEN  output  1  one-cycle move strobe to all units and enemies.
REQ-009 damageSCEN  output  1  one-cycle damage-apply strobe to all units and enemies.
REQ-010 enemyFront  output  9  maximum position of alive enemies; 0 when none are alive.
REQ-011 unitFront  output  9  minimum position of alive units; 511 when none are alive.
REQ-012 unitDamageBus  output  32  per-slot damageIn for units; non-zero only in slot unitTarget.
REQ-013 enemyDamageBus  output  32  per-slot damageIn for enemies; non-zero only in slot enemyTarget.
REQ-014 unitTarget, enemyTarget  output  2/2  index of the front alive unit or enemy.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 Edge detection: register gameClk; a tick is detected when the registered value is 0 and the current sample is 1, and the FSM is in IDLE.
REQ-017 A tick detected outside IDLE is dropped; no queueing.
REQ-018 FSM states are IDLE -> SCAN (4 cycles, index 0..3) -> MOVE (1) -> SETTLE (1) -> SUM (4 cycles, index 0..3) -> DAMAGE (1) -> IDLE.
REQ-019 SCAN handles one unit slot and one enemy slot per cycle: alive means type != 00; it tracks the minimum alive unitPos and the maximum alive enemyPos.
REQ-020 Ties: the lowest slot index wins both the front position and the target index.
REQ-021 No alive unit: unitFront = 511, unitTarget = 0, and unitDamageBus stays all-zero.
REQ-022 No alive enemy: enemyFront = 0, enemyTarget = 0, and enemyDamageBus stays all-zero.
REQ-023 enemyFront, unitFront and both targets are registered on entry to MOVE and held until the next MOVE.
REQ-024 moveSCEN is high for exactly the single MOVE cycle, which is the 5th cycle after the detection cycle.
REQ-025 SETTLE lets the units register their new damageOut before it is summed.
REQ-026 SUM accumulates in 8 bits: the enemy-damage sum totals enemyDmg of alive enemies, and the unit-damage sum totals unitDmg of alive units.
REQ-027 On entry to DAMAGE, the enemy-damage sum is written to the unitTarget slot of unitDamageBus and the unit-damage sum to the enemyTarget slot of enemyDamageBus; all other slots are 0.
REQ-028 damageSCEN is high for exactly the single DAMAGE cycle, which is 6 cycles after the moveSCEN cycle.
REQ-029 The damage buses hold their values until SUM index 0 of the next round, then clear to 0.
REQ-030 moveSCEN and damageSCEN are never high in the same cycle.
REQ-031 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-032 When reset is low on a clk edge, FSM = IDLE, and all internal accumulators and indices clear.
REQ-033 Output values while reset is asserted: moveSCEN = 0, damageSCEN = 0, busy = 0, unitFront = 511, enemyFront = 0, targets = 0, damage buses = 0.
REQ-034 The registered gameClk sample is loaded with the current gameClk, so a level already high at release does not start a round.
REQ-035 Reset mid-round aborts immediately; no strobe is issued on that edge or afterwards.

Configuration
REQ-036 Macro BATTLEFRONT_SATURATE_EN defined: both damage sums saturate at 255.
REQ-037 Macro BATTLEFRONT_SATURATE_EN undefined: both damage sums wrap modulo 256.

Verification
REQ-038 Units at 300/400/dead/dead, enemies at 100/150/dead/dead, one tick -> moveSCEN one cycle 5 cycles after detection; unitFront = 300, unitTarget = 0; enemyFront = 150, enemyTarget = 1.
REQ-039 Enemy damage 40 and 50, unit damage 32 in slot 0 after the move -> damageSCEN 6 cycles after moveSCEN; unitDamageBus slot 0 = 90, enemyDamageBus slot 1 = 32, all other slots 0.
REQ-040 All enemies dead, one tick -> enemyFront = 0, enemyDamageBus all-zero, both strobes still issued.
REQ-041 Enemy damage 128 and 128 -> 255 with BATTLEFRONT_SATURATE_EN defined; 0 without it.
REQ-042 Second gameClk rise during SUM -> ignored: exactly one moveSCEN and one damageSCEN for that round.
REQ-043 Reset low during SETTLE -> no damageSCEN; outputs take the REQ-033 values; a subsequent tick runs a full round.
